// File: rtl/pic8259_pkg.sv
// Shared encodings for the 8259A-subset interrupt controller: init FSM states,
// command-decode fields and the spurious IR number.
package pic8259_pkg;

  localparam int unsigned NUM_IR = 8;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] ST_UNINIT = 3'd0;
  localparam logic [ST_W-1:0] ST_ICW2   = 3'd1;
  localparam logic [ST_W-1:0] ST_ICW3   = 3'd2;
  localparam logic [ST_W-1:0] ST_ICW4   = 3'd3;
  localparam logic [ST_W-1:0] ST_READY  = 3'd4;

  localparam int unsigned ICW1_BIT     = 4;
  localparam int unsigned OCW3_RR_BIT  = 1;
  localparam int unsigned OCW3_RIS_BIT = 0;

  localparam logic [2:0] OCW2_EOI_NS  = 3'b001;
  localparam logic [2:0] OCW2_EOI_SP  = 3'b011;
  localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
  localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

  localparam logic [2:0] SPURIOUS_IR = 3'd7;

  localparam logic [1:0] INTA_IDLE = 2'd0;
  localparam logic [1:0] INTA_ONE  = 2'd1;
  localparam logic [1:0] INTA_TWO  = 2'd2;

endpackage

// File: rtl/pic_priority.sv
// Fixed-priority resolver (IR0 highest): picks the best unmasked request that
// outranks everything in service, and reports the highest in-service level.
module pic_priority
  import pic8259_pkg::*;
(
  input  logic [NUM_IR-1:0] irr_i,
  input  logic [NUM_IR-1:0] imr_i,
  input  logic [NUM_IR-1:0] isr_i,
  output logic              valid_o,
  output logic [2:0]        idx_o,
  output logic [2:0]        isr_top_o
);

  logic [NUM_IR-1:0] cand;
  logic              blocked;
  logic              found;

  assign cand = irr_i & ~imr_i;

  // A request at or below the first in-service level cannot win.
  always_comb begin
    valid_o   = 1'b0;
    idx_o     = 3'd0;
    isr_top_o = 3'd0;
    blocked   = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < int'(NUM_IR); i++) begin
      if (isr_i[i] && !blocked) begin
        isr_top_o = 3'(i);
      end
      if (isr_i[i]) begin
        blocked = 1'b1;
      end
      if (!blocked && !found && cand[i]) begin
        found = 1'b1;
        idx_o = 3'(i);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/intel8259.sv
// 8259A-subset programmable interrupt controller, 8086 mode: ICW1-4 init,
// OCW1-3, edge-triggered requests, fixed priority and the two-pulse INTA cycle.
module intel8259
  import pic8259_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              zclk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              a0,
  input  logic              inta_n,
  input  logic [NUM_IR-1:0] irq,
  inout  wire  [NUM_IR-1:0] d,
  output logic              intr
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SS-1:0][NUM_IR-1:0] sync_q;
  logic [NUM_IR-1:0] hist_q, hist_d;
  logic [NUM_IR-1:0] imr_q, imr_d;
  logic [NUM_IR-1:0] irr_q, irr_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [ST_W-1:0]   state_q, state_d;
  logic [4:0]        base_q, base_d;
  logic              ic4_q, ic4_d;
  logic              sngl_q, sngl_d;
  logic              aeoi_q, aeoi_d;
  logic              rsel_q, rsel_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        vec_q, vec_d;
  logic              spur_q, spur_d;
  logic              intr_q, intr_d;
  logic              wr_n_q;
  logic              inta_n_q;

  logic [NUM_IR-1:0] irq_s;
  logic [NUM_IR-1:0] rise;
  logic [NUM_IR-1:0] rd_data;
  logic              wr_acc;
  logic              inta_fall;
  logic              inta_rise;
  logic              rd_en;
  logic              vec_en;
  logic              pri_valid;
  logic [2:0]        pri_idx;
  logic [2:0]        isr_top;

  assign irq_s     = sync_q[SS-1];
  assign rise      = irq_s & ~hist_q;
  assign wr_acc    = ~cs_n & ~wr_n & wr_n_q;
  assign inta_fall = inta_n_q & ~inta_n;
  assign inta_rise = ~inta_n_q & inta_n;

  pic_priority u_pri (
    .irr_i     (irr_q),
    .imr_i     (imr_q),
    .isr_i     (isr_q),
    .valid_o   (pri_valid),
    .idx_o     (pri_idx),
    .isr_top_o (isr_top)
  );

  // Bus drive: vector during the counted second INTA pulse, else register read.
  assign rd_en   = ~cs_n & ~rd_n;
  assign vec_en  = (cnt_q == INTA_TWO) & ~inta_n;
  assign rd_data = a0 ? imr_q : (rsel_q ? isr_q : irr_q);
  assign d       = vec_en ? {base_q, vec_q} : (rd_en ? rd_data : {NUM_IR{1'bz}});
  assign intr    = intr_q;

  always_ff @(posedge zclk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      hist_q   <= '0;
      imr_q    <= '0;
      irr_q    <= '0;
      isr_q    <= '0;
      state_q  <= ST_UNINIT;
      base_q   <= '0;
      ic4_q    <= 1'b0;
      sngl_q   <= 1'b0;
      aeoi_q   <= 1'b0;
      rsel_q   <= 1'b0;
      cnt_q    <= INTA_IDLE;
      vec_q    <= '0;
      spur_q   <= 1'b0;
      intr_q   <= 1'b0;
      wr_n_q   <= 1'b1;
      inta_n_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SS-2:0], irq};
      hist_q   <= hist_d;
      imr_q    <= imr_d;
      irr_q    <= irr_d;
      isr_q    <= isr_d;
      state_q  <= state_d;
      base_q   <= base_d;
      ic4_q    <= ic4_d;
      sngl_q   <= sngl_d;
      aeoi_q   <= aeoi_d;
      rsel_q   <= rsel_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      spur_q   <= spur_d;
      intr_q   <= intr_d;
      wr_n_q   <= wr_n;
      inta_n_q <= inta_n;
    end
  end

  always_comb begin
    hist_d  = irq_s;
    imr_d   = imr_q;
    irr_d   = irr_q;
    isr_d   = isr_q;
    state_d = state_q;
    base_d  = base_q;
    ic4_d   = ic4_q;
    sngl_d  = sngl_q;
    aeoi_d  = aeoi_q;
    rsel_d  = rsel_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    spur_d  = spur_q;
    intr_d  = (state_q == ST_READY) & pri_valid;

    // INTA: freeze the winner on the first pulse, release it after the second.
    if (inta_fall) begin
      if (cnt_q == INTA_IDLE) begin
        cnt_d  = INTA_ONE;
        spur_d = ~pri_valid;
        vec_d  = pri_valid ? pri_idx : SPURIOUS_IR;
        if (pri_valid) begin
          isr_d[pri_idx] = 1'b1;
          irr_d[pri_idx] = 1'b0;
        end
      end else if (cnt_q == INTA_ONE) begin
        cnt_d = INTA_TWO;
      end
    end else if (inta_rise && cnt_q == INTA_TWO) begin
      cnt_d = INTA_IDLE;
      if (aeoi_q && !spur_q) begin
        isr_d[vec_q] = 1'b0;
      end
    end

    // A fresh edge wins over the INTA clear of the same bit.
    if (state_q == ST_READY) begin
      irr_d = irr_d | rise;
    end

    if (wr_acc) begin
      if (!a0 && d[ICW1_BIT]) begin
        imr_d   = '0;
        isr_d   = '0;
        irr_d   = '0;
        hist_d  = '0;
        cnt_d   = INTA_IDLE;
        rsel_d  = 1'b0;
        ic4_d   = d[0];
        sngl_d  = d[1];
        state_d = ST_ICW2;
      end else begin
        case (state_q)
          ST_ICW2: begin
            if (a0) begin
              base_d = d[7:3];
              if (!sngl_q)     state_d = ST_ICW3;
              else if (ic4_q)  state_d = ST_ICW4;
              else             state_d = ST_READY;
            end
          end
          ST_ICW3: begin
            if (a0) state_d = ic4_q ? ST_ICW4 : ST_READY;
          end
          ST_ICW4: begin
            if (a0) begin
              aeoi_d  = d[1];
              state_d = ST_READY;
            end
          end
          ST_READY: begin
            if (a0) begin
              imr_d = d;
            end else if (d[4:3] == OCW_SEL_OCW2) begin
              if (d[7:5] == OCW2_EOI_NS)      isr_d[isr_top] = 1'b0;
              else if (d[7:5] == OCW2_EOI_SP) isr_d[d[2:0]]  = 1'b0;
            end else if (d[4:3] == OCW_SEL_OCW3 && d[OCW3_RR_BIT]) begin
              rsel_d = d[OCW3_RIS_BIT];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_intel8259.sv
// Scoreboard bench for intel8259: directed scenarios plus randomized traffic
// checked against a register-level behavioural model.
module tb_intel8259;

  logic       zclk = 1'b0;
  logic       rst, cs_n, rd_n, wr_n, a0, inta_n;
  logic [7:0] irq;
  logic       intr;
  logic       tb_oe;
  logic [7:0] tb_dat;
  wire  [7:0] d_bus;

  // Undriven bus reads as 0xFF, so high-Z is observable.
  assign d_bus = tb_oe ? tb_dat : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (d_bus[g]);
  end

  intel8259 #(.SYNC_STAGES(2)) dut (
    .zclk   (zclk),
    .rst    (rst),
    .cs_n   (cs_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .a0     (a0),
    .inta_n (inta_n),
    .irq    (irq),
    .d      (d_bus),
    .intr   (intr)
  );

  always #5 zclk = ~zclk;

  typedef struct {
    string      name;
    bit         is_intr;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  logic probe   = 1'b0;
  logic fin_req = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  // Monitor: pops one expectation per probed cycle and compares.
  always @(negedge zclk) begin
    if (probe) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: probe with no expectation");
      end else begin
        exp_t       e;
        logic [7:0] act;
        e   = exp_q.pop_front();
        act = e.is_intr ? {7'b0, intr} : d_bus;
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %02h want %02h", e.name, act, e.val);
        end
      end
    end
    if (fin_req) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge zclk);
    #1;
  endtask

  task automatic expect_now(input string name, input bit is_intr, input logic [7:0] val);
    exp_t e;
    e.name = name; e.is_intr = is_intr; e.val = val;
    exp_q.push_back(e);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  task automatic wr(input logic a, input logic [7:0] v);
    cs_n = 1'b0; wr_n = 1'b0; a0 = a; tb_oe = 1'b1; tb_dat = v;
    tick(1);
    cs_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
    tick(1);
  endtask

  task automatic rd(input logic a, input logic [7:0] v, input string name);
    cs_n = 1'b0; rd_n = 1'b0; a0 = a;
    expect_now(name, 1'b0, v);
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic chk_intr(input logic v, input string name);
    expect_now(name, 1'b1, {7'b0, v});
  endtask

  task automatic inta_pulse(input logic [7:0] v, input string name);
    inta_n = 1'b0;
    tick(1);
    expect_now(name, 1'b0, v);
    inta_n = 1'b1;
    tick(2);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_irr, m_isr, m_imr, m_lines;
  logic [4:0] m_base;
  bit         m_aeoi;

  function automatic int winner(input logic [7:0] irr_v, input logic [7:0] imr_v,
                                input logic [7:0] isr_v);
    int top = 8;
    for (int i = 7; i >= 0; i--) if (isr_v[i]) top = i;
    for (int i = 0; i < top; i++) if (irr_v[i] && !imr_v[i]) return i;
    return -1;
  endfunction

  task automatic model_inta();
    int w;
    logic [2:0] w3;
    w  = winner(m_irr, m_imr, m_isr);
    w3 = (w < 0) ? 3'd7 : 3'(w);
    if (w >= 0) begin
      m_isr[w3] = 1'b1;
      m_irr[w3] = 1'b0;
    end
    inta_pulse(8'hFF, "rnd_inta1_hiz");
    inta_pulse({m_base, w3}, "rnd_vector");
    if (m_aeoi && w >= 0) m_isr[w3] = 1'b0;
  endtask

  task automatic model_reads();
    wr(1'b0, 8'h0A);
    rd(1'b0, m_irr, "rnd_irr");
    wr(1'b0, 8'h0B);
    rd(1'b0, m_isr, "rnd_isr");
    rd(1'b1, m_imr, "rnd_imr");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; inta_n = 1'b1;
    irq = 8'h00; tb_oe = 1'b0; tb_dat = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk_intr(1'b0, "reset_intr");
    expect_now("reset_bus_hiz", 1'b0, 8'hFF);
    rd(1'b1, 8'h00, "reset_imr");
    rd(1'b0, 8'h00, "reset_irr");

    // Init and IR0 service
    wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h09); wr(1'b1, 8'hFE);
    irq = 8'h01;
    tick(3);
    chk_intr(1'b0, "ir0_intr_k2");
    chk_intr(1'b1, "ir0_intr_k3");
    irq = 8'h00;
    inta_pulse(8'hFF, "ir0_inta1_hiz");
    inta_pulse(8'h08, "ir0_vector");
    wr(1'b0, 8'h0B);
    rd(1'b0, 8'h01, "ir0_isr");
    wr(1'b0, 8'h20);
    rd(1'b0, 8'h00, "ir0_isr_after_eoi");
    chk_intr(1'b0, "ir0_intr_after_eoi");

    // Priority and nesting
    wr(1'b1, 8'h00);
    irq = 8'h0A;
    tick(5);
    irq = 8'h00;
    wr(1'b0, 8'h0A);
    rd(1'b0, 8'h0A, "nest_irr");
    chk_intr(1'b1, "nest_intr");
    inta_pulse(8'hFF, "nest_inta1_hiz");
    inta_pulse(8'h09, "nest_vector_ir1");
    irq = 8'h01;
    tick(5);
    irq = 8'h00;
    chk_intr(1'b1, "nest_ir0_preempt_intr");
    inta_pulse(8'hFF, "nest_ir0_inta1_hiz");
    inta_pulse(8'h08, "nest_vector_ir0");
    wr(1'b0, 8'h0B);
    rd(1'b0, 8'h03, "nest_isr_both");
    wr(1'b0, 8'h20);
    rd(1'b0, 8'h02, "nest_isr_after_eoi1");
    chk_intr(1'b0, "nest_ir3_blocked");
    wr(1'b0, 8'h20);
    chk_intr(1'b1, "nest_ir3_after_eoi2");
    inta_pulse(8'hFF, "nest_ir3_inta1_hiz");
    inta_pulse(8'h0B, "nest_vector_ir3");
    rd(1'b0, 8'h08, "spec_isr_before");
    wr(1'b0, 8'h63);
    rd(1'b0, 8'h00, "spec_eoi_isr");

    // Masking
    wr(1'b1, 8'h04);
    irq = 8'h04;
    tick(5);
    irq = 8'h00;
    chk_intr(1'b0, "mask_intr");
    wr(1'b0, 8'h0A);
    rd(1'b0, 8'h04, "mask_irr");
    wr(1'b1, 8'h00);
    chk_intr(1'b1, "unmask_intr");
    inta_pulse(8'hFF, "mask_inta1_hiz");
    inta_pulse(8'h0A, "mask_vector");
    wr(1'b0, 8'h20);

    // Held-high line does not re-request
    irq = 8'h10;
    tick(5);
    inta_pulse(8'hFF, "hold_inta1_hiz");
    inta_pulse(8'h0C, "hold_vector");
    wr(1'b0, 8'h20);
    tick(5);
    chk_intr(1'b0, "hold_no_rerequest");
    rd(1'b0, 8'h00, "hold_irr");
    irq = 8'h00;
    tick(3);

    // Spurious and AEOI
    wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h0B);
    inta_pulse(8'hFF, "spur_inta1_hiz");
    inta_pulse(8'h0F, "spur_vector");
    wr(1'b0, 8'h0B);
    rd(1'b0, 8'h00, "spur_isr");
    irq = 8'h20;
    tick(5);
    irq = 8'h00;
    chk_intr(1'b1, "aeoi_intr");
    inta_pulse(8'hFF, "aeoi_inta1_hiz");
    inta_pulse(8'h0D, "aeoi_vector");
    rd(1'b0, 8'h00, "aeoi_isr_cleared");
    chk_intr(1'b0, "aeoi_intr_low");

    // Reset between the two INTA pulses
    wr(1'b1, 8'h80);
    irq = 8'h40;
    tick(5);
    irq = 8'h00;
    chk_intr(1'b1, "rstmid_intr_before");
    inta_pulse(8'hFF, "rstmid_inta1_hiz");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk_intr(1'b0, "rstmid_intr");
    rd(1'b1, 8'h00, "rstmid_imr");
    rd(1'b0, 8'h00, "rstmid_irr");
    inta_pulse(8'hFF, "rstmid_next_pulse_hiz");

    // Randomized traffic against the model
    for (int r = 0; r < 3; r++) begin
      m_base = 5'($urandom_range(0, 30));
      m_aeoi = 1'($urandom_range(0, 1));
      wr(1'b0, 8'h11);
      wr(1'b1, {m_base, 3'b000});
      wr(1'b1, 8'h00);
      wr(1'b1, m_aeoi ? 8'h03 : 8'h01);
      m_irr = 8'h00; m_isr = 8'h00; m_lines = 8'h00;
      m_imr = 8'($urandom & $urandom);
      wr(1'b1, m_imr);
      for (int n = 0; n < 25; n++) begin
        case ($urandom_range(0, 4))
          0: begin
            logic [7:0] nl;
            nl = 8'($urandom);
            irq = nl;
            m_irr = m_irr | (nl & ~m_lines);
            m_lines = nl;
            tick(5);
          end
          1: begin
            m_imr = 8'($urandom & $urandom);
            wr(1'b1, m_imr);
          end
          4: begin
            if ($urandom_range(0, 1) == 0) begin
              for (int i = 0; i < 8; i++) begin
                if (m_isr[i]) begin
                  m_isr[i] = 1'b0;
                  break;
                end
              end
              wr(1'b0, 8'h20);
            end else begin
              logic [2:0] b;
              b = 3'($urandom_range(0, 7));
              m_isr[b] = 1'b0;
              wr(1'b0, {3'b011, 2'b00, b});
            end
          end
          default: model_inta();
        endcase
        chk_intr(winner(m_irr, m_imr, m_isr) >= 0, "rnd_intr");
        if (n % 5 == 4) model_reads();
      end
      irq = 8'h00;
      tick(5);
    end

    tick(2);
    fin_req = 1'b1;
    tick(1);
    fin_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intel8259.md
# intel8259

Programmable interrupt controller, a single-chip 8259A subset for 8086 mode. It consumes timer channel 0 output as IR0 and seven other peripheral request lines. It raises `intr` to the CPU and supplies the interrupt vector on the second INTA pulse. It shares the 8-bit CPU data bus with the interval timer.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on each `irq` input (minimum 2).
- `zclk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cs_n` input 1: chip select, active low.
- `rd_n` input 1: read strobe, active low.
- `wr_n` input 1: write strobe, active low.
- `a0` input 1: register address bit.
- `inta_n` input 1: interrupt acknowledge strobe from the CPU, active low.
- `irq` input 8: request lines IR7..IR0; IR0 is timer channel 0 output. Inputs are asynchronous to `zclk`.
- `d` inout 8: data bus. Driven only during a register read or the second INTA pulse; otherwise high-Z.
- `intr` output 1: interrupt request to the CPU, registered.

## Operation
- **Init FSM states:** UNINIT, ICW2, ICW3, ICW4, READY.
- **Write accept rule:** a write is accepted once per strobe, on the first `zclk` edge where `cs_n=0`, `wr_n=0` and the registered `wr_n` of the previous cycle was 1.
- **ICW1** (`a0=0`, `d[4]=1`), accepted in any state:
  - clears IMR, ISR, IRR, edge history and the INTA counter;
  - selects IRR for reads;
  - stores IC4=`d[0]` and SNGL=`d[1]`;
  - next state is ICW2.
- **ICW2** (`a0=1`): vector base = `d[7:3]`. Next state is ICW4 if SNGL=1 and IC4=1, ICW3 if SNGL=0, READY otherwise.
- **ICW3** (`a0=1`): data discarded. Next state is ICW4 if IC4=1, else READY.
- **ICW4** (`a0=1`): AEOI=`d[1]`; other bits ignored. Next state is READY.
- **In READY:**
  - `a0=1` write: OCW1, IMR=`d`.
  - `a0=0`, `d[4:3]=00`: OCW2.
    - `d[7:5]=001`: non-specific EOI, clears the highest-priority set ISR bit.
    - `d[7:5]=011`: specific EOI, clears ISR[`d[2:0]`].
    - Other OCW2 codes: ignored.
  - `a0=0`, `d[4:3]=01`: OCW3. If `d[1]=1`, read select = ISR when `d[0]=1`, IRR when `d[0]=0`.
- **Reads** (`cs_n=0`, `rd_n=0`, combinational drive): `a0=1` returns IMR; `a0=0` returns IRR or ISR according to the read select.
- **Request capture:**
  - Edge-triggered only. A rising edge of the synchronized `irq[i]` sets IRR[i].
  - A held-high line does not re-request.
  - Edges are tracked in all states, but IRR only sets in READY.
- **Priority:** fixed, IR0 highest.
  - Candidate set = IRR & ~IMR.
  - Candidates are eligible only if strictly higher priority than the highest set ISR bit.
  - `intr` = READY & (an eligible candidate exists), registered.
- **INTA sequence** (counted on `inta_n` falling edges, sampled on `zclk`):
  - First pulse: freeze the winner W. Set ISR[W], clear IRR[W]. `d` stays high-Z.
  - Second pulse: drive `d` = {base, W} while `inta_n=0`. If AEOI=1, clear ISR[W] on the `inta_n` rising edge that ends this pulse. The counter then returns to 0.
  - No eligible candidate at the first pulse (spurious): W=7, ISR unchanged, vector = {base, 3'b111}.
- **Same-cycle conflicts:**
  - Edge on bit i in the same cycle that the first INTA clears IRR[i]: IRR[i] stays 1 (the new request is kept).
  - EOI and ISR set in the same cycle: both apply, to their own bits.
- **Reset (any time):**
  - State UNINIT; IMR, IRR, ISR, AEOI, base, INTA counter, synchronizers and edge history all 0.
  - `intr=0`; `d` high-Z.
  - A reset mid-INTA abandons the sequence.

## Timing
- **IRQ latency:** `irq` rises before zclk edge k. With `SYNC_STAGES=2`, IRR sets at edge k+2 and `intr` rises at edge k+3.
- **Read:** `d` is valid combinationally from `cs_n`/`rd_n`/`a0`, with no latency. The value reflects register contents as of the last edge.
- **Write:** the register updates on the acceptance edge and is visible to reads one cycle later.
- **INTA:**
  - ISR/IRR update on the edge that detects the first `inta_n` falling edge.
  - `intr` falls one edge later if nothing else is eligible.
  - Vector drive starts combinationally once the second-pulse falling edge has been counted. That is at most one `zclk` after `inta_n` falls; the CPU holds `inta_n` low for at least 2 `zclk`.
- **EOI:** ISR clears on the acceptance edge. A pending lower-priority request raises `intr` one edge later.

## Structure
- **Package `pic8259_pkg`:** FSM state encodings; command-decode constants (ICW1 flag bit, OCW2 EOI codes 001/011, OCW3 select bit); spurious IR number 7.
- **Sub-module `pic_priority`:** combinational 8-in resolver taking IRR, IMR and ISR. Outputs:
  - `valid`: an eligible candidate exists;
  - `idx[2:0]`: the winning candidate;
  - `isr_top[2:0]`: the highest set ISR bit, used by non-specific EOI.

  Instantiated once.
- Everything else stays in `intel8259`.

## Test plan
- **Init and IR0 service:**
  - Stimulus: ICW1=0x13, ICW2=0x08, ICW4=0x09, OCW1=0xFE; pulse `irq[0]` high.
  - Required: `intr` rises at edge k+3. The two INTA pulses put 0x08 on `d`. An ISR read (OCW3=0x0B) returns 0x01. OCW2=0x20 clears it to 0x00.
- **Priority and nesting:**
  - Stimulus: edges on IR3 and IR1 in the same cycle; then service IR1 and raise IR0 before its EOI.
  - Required: first vector 0x09. IR0 preempts (vector 0x08) while ISR=0x02; ISR=0x03 until EOIs.
- **Masking:**
  - Stimulus: IMR=0x04, edge on IR2.
  - Required: IRR=0x04, `intr` stays 0. Writing IMR=0x00 raises `intr` next edge.
- **Spurious and AEOI:**
  - Stimulus: init with ICW4=0x0B; run INTA with no request; then service IR5.
  - Required: spurious vector 0x0F with ISR=0x00. The IR5 vector is 0x0D, and ISR returns to 0x00 after the second pulse without any EOI.
- **Boundaries:**
  - Stimulus: hold `irq[4]` high across an EOI; issue a specific EOI 0x63 with ISR=0x08; assert `rst` between the two INTA pulses.
  - Required: no second IR4 request; ISR=0x00 after the specific EOI. After the mid-INTA reset, `intr=0`, all registers 0, `d` high-Z on the next `inta_n` pulse.
